// File: rtl/cpu.sv
// Multi-cycle TSC CPU (IF/ID/EX/MEM/WB, one instruction in flight) on a shared read/write memory bus.
// Define CPU_ILLEGAL_HALT_EN to halt on undefined opcodes/funcs; by default they retire as NOPs.
module cpu #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic [WORD_SIZE-1:0] output_port,
  output logic                 is_halted
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;

  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_R   = 4'd15;

  state_t               state_q;
  logic [WORD_SIZE-1:0] pc_q, ir_q, a_q, b_q, res_q, addr_q, wdata_q, num_q, out_q;
  logic [WORD_SIZE-1:0] rf_q [4];
  logic                 readM_q, writeM_q, halted_q;

  logic [3:0]           op;
  logic [1:0]           rs, rt, rd, dst_d;
  logic [5:0]           fn;
  logic [WORD_SIZE-1:0] sext_imm, zext_imm, pc1, jmp_tgt, npc_d, alu_d;
  logic                 taken, illegal_d, to_wb, is_mem, is_hlt, is_wwd, is_link;

  always_comb begin
    op        = ir_q[15:12];
    rs        = ir_q[11:10];
    rt        = ir_q[9:8];
    rd        = ir_q[7:6];
    fn        = ir_q[5:0];
    sext_imm  = {{(WORD_SIZE-8){ir_q[7]}}, ir_q[7:0]};
    zext_imm  = {{(WORD_SIZE-8){1'b0}}, ir_q[7:0]};
    pc1       = pc_q + WORD_SIZE'(1);
    jmp_tgt   = {pc_q[WORD_SIZE-1:12], ir_q[11:0]};
    npc_d     = pc1;
    alu_d     = '0;
    taken     = 1'b0;
    illegal_d = 1'b0;
    to_wb     = 1'b0;
    is_hlt    = 1'b0;
    is_wwd    = 1'b0;
    is_link   = 1'b0;
    dst_d     = (op == OP_R) ? rd : rt;
    is_mem    = (op == OP_LWD) || (op == OP_SWD);
    case (op)
      4'd0:  taken = (a_q != b_q);
      4'd1:  taken = (a_q == b_q);
      4'd2:  taken = !a_q[WORD_SIZE-1] && (a_q != '0);
      4'd3:  taken = a_q[WORD_SIZE-1];
      4'd4:  begin alu_d = a_q + sext_imm; to_wb = 1'b1; end
      4'd5:  begin alu_d = a_q | zext_imm; to_wb = 1'b1; end
      4'd6:  begin alu_d = WORD_SIZE'({ir_q[7:0], 8'h00}); to_wb = 1'b1; end
      4'd7, 4'd8: ;
      4'd9:  npc_d = jmp_tgt;
      4'd10: begin npc_d = jmp_tgt; is_link = 1'b1; end
      4'd15: begin
        case (fn)
          6'd0:  begin alu_d = a_q + b_q; to_wb = 1'b1; end
          6'd1:  begin alu_d = a_q - b_q; to_wb = 1'b1; end
          6'd2:  begin alu_d = a_q & b_q; to_wb = 1'b1; end
          6'd3:  begin alu_d = a_q | b_q; to_wb = 1'b1; end
          6'd4:  begin alu_d = ~a_q; to_wb = 1'b1; end
          6'd5:  begin alu_d = -a_q; to_wb = 1'b1; end
          6'd6:  begin alu_d = a_q << 1; to_wb = 1'b1; end
          6'd7:  begin alu_d = $signed(a_q) >>> 1; to_wb = 1'b1; end
          6'd25: npc_d = a_q;
          6'd26: begin npc_d = a_q; is_link = 1'b1; end
          6'd28: is_wwd = 1'b1;
          6'd29: is_hlt = 1'b1;
          default: illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase
    if (taken) npc_d = pc1 + sext_imm;
  end

  // Every retiring path sets readM_q and addr_q so the next fetch request is already up in IF.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q  <= S_IF;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      num_q    <= '0;
      out_q    <= '0;
      readM_q  <= 1'b0;
      writeM_q <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else if (!halted_q) begin
      case (state_q)
        S_IF: begin
          if (!readM_q) begin
            readM_q <= 1'b1;
            addr_q  <= pc_q;
          end else if (inputReady) begin
            ir_q    <= data;
            readM_q <= 1'b0;
            state_q <= S_ID;
          end
        end
        S_ID: begin
          a_q     <= rf_q[rs];
          b_q     <= rf_q[rt];
          state_q <= S_EX;
        end
        S_EX: begin
          if (is_hlt) halted_q <= 1'b1;
`ifdef CPU_ILLEGAL_HALT_EN
          else if (illegal_d) halted_q <= 1'b1;
`endif
          else if (is_mem) begin
            addr_q   <= a_q + sext_imm;
            wdata_q  <= b_q;
            readM_q  <= (op == OP_LWD);
            writeM_q <= (op == OP_SWD);
            state_q  <= S_MEM;
          end else if (to_wb) begin
            res_q   <= alu_d;
            state_q <= S_WB;
          end else begin
            if (is_link) rf_q[2] <= pc1;
            if (is_wwd) out_q <= a_q;
            pc_q    <= npc_d;
            addr_q  <= npc_d;
            readM_q <= 1'b1;
            num_q   <= num_q + WORD_SIZE'(1);
            state_q <= S_IF;
          end
        end
        S_MEM: begin
          if (inputReady) begin
            writeM_q <= 1'b0;
            if (writeM_q) begin
              pc_q    <= pc1;
              addr_q  <= pc1;
              readM_q <= 1'b1;
              num_q   <= num_q + WORD_SIZE'(1);
              state_q <= S_IF;
            end else begin
              readM_q <= 1'b0;
              res_q   <= data;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          rf_q[dst_d] <= res_q;
          pc_q        <= pc1;
          addr_q      <= pc1;
          readM_q     <= 1'b1;
          num_q       <= num_q + WORD_SIZE'(1);
          state_q     <= S_IF;
        end
        default: state_q <= S_IF;
      endcase
    end
  end

  assign data        = writeM_q ? wdata_q : 'z;
  assign readM       = readM_q;
  assign writeM      = writeM_q;
  assign address     = addr_q;
  assign num_inst    = num_q;
  assign output_port = out_q;
  assign is_halted   = halted_q;
endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: random and directed programs checked against an ISA-level model.
`timescale 1ns/1ps
module tb_cpu;
  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        inputReady = 1'b0;
  logic        readM, writeM, is_halted;
  logic [15:0] address, num_inst, output_port;
  wire  [15:0] data;
  logic        drv_en = 1'b0;
  logic [15:0] drv_val = 16'h0;

  assign data = drv_en ? drv_val : 'z;

  cpu #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n), .readM(readM), .writeM(writeM),
    .address(address), .data(data), .inputReady(inputReady),
    .num_inst(num_inst), .output_port(output_port), .is_halted(is_halted)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  logic [15:0] mem [0:65535];
  logic [15:0] mm  [0:65535];
  logic [15:0] mreg [4];
  logic [15:0] mpc, mout;
  bit          mhalt;
  int          mcnt;
  txn_t        txq [$];
  logic [15:0] exp_out [0:255];
  int          exp_lat [0:255];
  bit          mem_en = 1'b0, done = 1'b0, lat_chk = 1'b0, fixed_dly = 1'b0;
  int          maxd = 0, wait_cnt = 0, comps = 0, since = 0, run_n = 0;
  logic [15:0] prev_num = 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ISA interpreter: fills the expected bus transactions, output_port and latency per instruction.
  task automatic model_run(input int n);
    logic [15:0] ins, a, t, se, npc;
    logic [3:0]  op;
    logic [1:0]  rs, rt, rd;
    logic [5:0]  fn;
    txn_t        x;
    int          lat;
    bit          halt, illegal;
    txq.delete();
    mcnt = 0; mhalt = 1'b0; mpc = 16'h0; mout = 16'h0;
    for (int i = 0; i < 4; i++) mreg[i] = 16'h0;
    while (mcnt < n && !mhalt) begin
      ins = mm[mpc];
      x = {1'b0, mpc, 16'h0}; txq.push_back(x);
      op = ins[15:12]; rs = ins[11:10]; rt = ins[9:8]; rd = ins[7:6]; fn = ins[5:0];
      se = {{8{ins[7]}}, ins[7:0]};
      npc = mpc + 16'd1; lat = 3; halt = 1'b0; illegal = 1'b0;
      case (op)
        4'd0: if (mreg[rs] != mreg[rt]) npc = mpc + 16'd1 + se;
        4'd1: if (mreg[rs] == mreg[rt]) npc = mpc + 16'd1 + se;
        4'd2: if ($signed(mreg[rs]) > $signed(16'h0)) npc = mpc + 16'd1 + se;
        4'd3: if ($signed(mreg[rs]) < $signed(16'h0)) npc = mpc + 16'd1 + se;
        4'd4: begin mreg[rt] = mreg[rs] + se; lat = 4; end
        4'd5: begin mreg[rt] = mreg[rs] | {8'h00, ins[7:0]}; lat = 4; end
        4'd6: begin mreg[rt] = {ins[7:0], 8'h00}; lat = 4; end
        4'd7: begin
          a = mreg[rs] + se; x = {1'b0, a, 16'h0}; txq.push_back(x);
          mreg[rt] = mm[a]; lat = 5;
        end
        4'd8: begin
          a = mreg[rs] + se; x = {1'b1, a, mreg[rt]}; txq.push_back(x);
          mm[a] = mreg[rt]; lat = 4;
        end
        4'd9:  npc = {mpc[15:12], ins[11:0]};
        4'd10: begin npc = {mpc[15:12], ins[11:0]}; mreg[2] = mpc + 16'd1; end
        4'd15: begin
          lat = 4;
          case (fn)
            6'd0: mreg[rd] = mreg[rs] + mreg[rt];
            6'd1: mreg[rd] = mreg[rs] - mreg[rt];
            6'd2: mreg[rd] = mreg[rs] & mreg[rt];
            6'd3: mreg[rd] = mreg[rs] | mreg[rt];
            6'd4: mreg[rd] = ~mreg[rs];
            6'd5: mreg[rd] = 16'd0 - mreg[rs];
            6'd6: mreg[rd] = {mreg[rs][14:0], 1'b0};
            6'd7: mreg[rd] = {mreg[rs][15], mreg[rs][15:1]};
            6'd25: begin npc = mreg[rs]; lat = 3; end
            6'd26: begin t = mreg[rs]; mreg[2] = mpc + 16'd1; npc = t; lat = 3; end
            6'd28: begin mout = mreg[rs]; lat = 3; end
            6'd29: halt = 1'b1;
            default: begin illegal = 1'b1; lat = 3; end
          endcase
        end
        default: illegal = 1'b1;
      endcase
`ifdef CPU_ILLEGAL_HALT_EN
      if (illegal) halt = 1'b1;
`endif
      if (halt) mhalt = 1'b1;
      else begin
        exp_out[mcnt] = mout;
        exp_lat[mcnt] = lat;
        mcnt++;
        mpc = npc;
      end
    end
  endtask

  // Memory responder and retirement monitor, both evaluated on the falling edge.
  initial begin : monitor
    txn_t e;
    forever begin
      @(negedge clk);
      since++;
      if (reset_n) begin
        prev_num = 16'h0; inputReady = 1'b0; drv_en = 1'b0;
      end else begin
        if (num_inst !== prev_num) begin
          prev_num = num_inst;
          if (comps < mcnt) begin
            check("num_inst", num_inst, 16'(comps + 1));
            check("output_port", output_port, exp_out[comps]);
            if (lat_chk && comps > 0) check("latency", since, exp_lat[comps]);
          end else check("retire_count", comps, mcnt - 1);
          comps++; since = 0;
          if (comps >= run_n) done = 1'b1;
        end
        inputReady = 1'b0; drv_en = 1'b0;
        if (mem_en) check("not_both", readM && writeM, 0);
        if (mem_en && !done && (readM || writeM)) begin
          if (wait_cnt > 0) wait_cnt--;
          else begin
            inputReady = 1'b1;
            check("txq_pending", txq.size() != 0, 1);
            if (txq.size() != 0) begin
              e = txq.pop_front();
              check("txn_write", writeM, e.wr);
              check("txn_addr", address, e.a);
              if (writeM) check("txn_data", data, e.d);
            end
            if (readM) begin drv_en = 1'b1; drv_val = mem[address]; end
            else mem[address] = data;
            wait_cnt = fixed_dly ? maxd : $urandom_range(maxd, 0);
          end
        end
      end
    end
  end

  task automatic do_reset();
    mem_en = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_readM", readM, 0);
    check("rst_writeM", writeM, 0);
    check("rst_num_inst", num_inst, 0);
    check("rst_output_port", output_port, 0);
    check("rst_is_halted", is_halted, 0);
    reset_n = 1'b0;
  endtask

  task automatic run_prog(input int n, input int md, input bit fixed, input bit lat);
    model_run(n);
    do_reset();
    run_n = mhalt ? mcnt + 1 : mcnt;
    maxd = md; fixed_dly = fixed; lat_chk = lat;
    wait_cnt = fixed ? md : $urandom_range(md, 0);
    comps = 0; done = 1'b0; since = 0;
    mem_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (done || is_halted) break;
    end
    check("completed", comps, mcnt);
    check("halted", is_halted, mhalt);
    check("txq_drained", txq.size(), 0);
    if (mhalt) begin
      if (lat && mcnt > 0) check("hlt_latency", since, 3);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk); #1;
        check("frz_num_inst", num_inst, 16'(mcnt));
        check("frz_output_port", output_port, mout);
        check("frz_readM", readM, 0);
        check("frz_writeM", writeM, 0);
        check("frz_is_halted", is_halted, 1);
      end
    end
    mem_en = 1'b0;
  endtask

  task automatic load_directed();
    logic [15:0] prog [0:17];
    prog = '{16'h6012, 16'hF01C, 16'h6000, 16'h41FD, 16'hF41C, 16'hF485, 16'hF81C,
             16'h0102, 16'hF01C, 16'hF01C, 16'h1102, 16'hA020, 16'h8130, 16'h7330,
             16'hFC1C, 16'hF447, 16'hF41C, 16'hF01D};
    for (int i = 0; i < 65536; i++) begin mem[i] = 16'h0; mm[i] = 16'h0; end
    for (int i = 0; i < 18; i++) begin mem[i] = prog[i]; mm[i] = prog[i]; end
    mem[16'h20] = 16'hF819; mm[16'h20] = 16'hF819;
  endtask

  task automatic load_random();
    logic [15:0] w;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF && w[5:0] == 6'd29) w[5:0] = 6'd28;
      mem[i] = w; mm[i] = w;
    end
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    load_directed(); run_prog(40, 0, 1'b1, 1'b1);
    load_directed(); run_prog(40, 3, 1'b1, 1'b0);
    // A fetch left waiting on memory must be abandoned by reset.
    do_reset();
    repeat (4) @(negedge clk);
    #1;
    check("wait_readM", readM, 1);
    check("wait_addr", address, 0);
    check("wait_writeM", writeM, 0);
    do_reset();
    load_random(); run_prog(100, 0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      load_random(); run_prog(100, 3, 1'b0, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter: WORD_SIZE, default 16, sets the data, address and instruction width; all widths below are WORD_SIZE.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  synchronous active-high reset; name kept per codebase, 1 = reset, sampled on clk rising edge.
REQ-004 Port: readM  output  1  memory read request; held until completion.
REQ-005 Port: writeM  output  1  memory write request; held until completion.
REQ-006 Port: address  output  16  memory address for the current read or write.
REQ-007 Port: data  inout  16  bidirectional memory data bus.
REQ-008 Port: inputReady  input  1  memory completion flag; read data valid, or write accepted.
REQ-009 Port: num_inst  output  16  count of completed instructions.
REQ-010 Port: output_port  output  16  value from the most recent WWD.
REQ-011 Port: is_halted  output  1  high after HLT completes.

Function
REQ-012 Multi-cycle TSC ISA SHALL use states IF, ID, EX, MEM, WB, with one instruction in flight.
REQ-013 Instruction fields: opcode[15:12], rs[11:10], rt[9:8], rd[7:6], func[5:0], imm[7:0] (sign-extended), target[11:0]; four 16-bit registers $0-$3.
REQ-014 R-type (opcode 15) func 0-7 SHALL execute as follows, writing rd: ADD, SUB (rs-rt), AND, ORR, NOT rs, TCP (-rs), SHL rs<<1, SHR arithmetic rs>>>1; arithmetic wraps mod 2^16 with no flags.
REQ-015 I-type: ADI(4) rt=rs+sext(imm); ORI(5) rt=rs|zext(imm); LHI(6) rt={imm,8'h00}; LWD(7) rt=M[rs+sext(imm)]; SWD(8) M[rs+sext(imm)]=rt.
REQ-016 Branches, taken target PC+1+sext(imm): BNE(0) rs!=rt; BEQ(1) rs==rt; BGZ(2) signed rs>0; BLZ(3) signed rs<0; not taken goes to PC+1.
REQ-017 Jumps: JMP(9) PC={PC[15:12],target}; JAL(10) same and $2=PC+1; JPR (15/25) PC=rs; JRL (15/26) PC=rs, $2=PC+1.
REQ-018 WWD (15/28) SHALL load output_port with rs; it holds until the next WWD.
REQ-019 HLT (15/29) SHALL set is_halted=1; no further fetch; all outputs frozen until reset.
REQ-020 Memory handshake: CPU asserts readM or writeM (never both) with a stable address; transfer completes on the first rising edge with inputReady=1; the request deasserts the next cycle.
REQ-021 CPU SHALL drive data only while writeM=1; otherwise the bus is high-Z.
REQ-022 num_inst SHALL increment by 1 on the final state of each instruction except HLT, wrapping at 0xFFFF.
REQ-023 Latency excluding memory wait: branch/jump/WWD 3 cycles; ALU and immediate 4; SWD 4; LWD 5.
REQ-024 Register and PC write for an instruction SHALL occur in the same edge as its num_inst increment.

Reset
REQ-025 While reset_n=1 at a rising edge: PC=0, $0-$3=0, num_inst=0, output_port=0, is_halted=0, readM=writeM=0, state=IF.
REQ-026 Reset mid-instruction or mid-memory-wait SHALL abort the operation with no register or memory write; fetch restarts from address 0 on the first edge after deassertion.

Configuration
REQ-027 Macro CPU_ILLEGAL_HALT_EN defined: an undefined opcode or func sets is_halted=1 as HLT does; undefined: it executes as a NOP and increments num_inst.

Verification
REQ-028 Reset, then LHI $0,0x12; WWD $0 -> output_port=0x1200, num_inst=2.
REQ-029 ADI $1,$0,0xFD with $0=0; WWD $1 -> output_port=0xFFFD; then TCP $2,$1; WWD $2 -> 0x0003.
REQ-030 BNE taken with $0!=$1, imm=2 -> next fetch address PC+3; BEQ same operands -> PC+1.
REQ-031 JAL 0x010 at PC=0x005 -> $2=0x0006, next fetch 0x010; JPR $2 -> next fetch 0x0006.
REQ-032 SWD $1,$0,0x20 then LWD $3,$0,0x20; WWD $3 -> output_port equals $1, with inputReady delayed 3 cycles.
REQ-033 HLT -> is_halted=1 next cycle; num_inst, readM and output_port frozen for 10 further cycles.
